// File: rtl/ita_scan_pkg.sv
// ita_scan_pkg: shared constants for the ita 14-segment scan monitor.
//   - Segment bit order (bit 13 down to 0): a b c d e f g1 g2 h i j k l m
//   - Glyph patterns for 0-9, A-Z and space, matching the ita display drivers
//   - Character codes: 0-9 digits, 10-35 letters, 36 space, 63 unknown
package ita_scan_pkg;

    localparam int NDIG = 12;
    localparam int CW   = 6;

    localparam logic [CW-1:0] CH_SPACE = 6'd36;
    localparam logic [CW-1:0] CH_UNK   = 6'd63;

    localparam logic [13:0] SEG_0 = 14'h3F0C;
    localparam logic [13:0] SEG_1 = 14'h1808;
    localparam logic [13:0] SEG_2 = 14'h36C0;
    localparam logic [13:0] SEG_3 = 14'h3C40;
    localparam logic [13:0] SEG_4 = 14'h19C0;
    localparam logic [13:0] SEG_5 = 14'h2DC0;
    localparam logic [13:0] SEG_6 = 14'h2FC0;
    localparam logic [13:0] SEG_7 = 14'h3800;
    localparam logic [13:0] SEG_8 = 14'h3FC0;
    localparam logic [13:0] SEG_9 = 14'h3DC0;
    localparam logic [13:0] SEG_A = 14'h3BC0;
    localparam logic [13:0] SEG_B = 14'h3C52;
    localparam logic [13:0] SEG_C = 14'h2700;
    localparam logic [13:0] SEG_D = 14'h3C12;
    localparam logic [13:0] SEG_E = 14'h2780;
    localparam logic [13:0] SEG_F = 14'h2380;
    localparam logic [13:0] SEG_G = 14'h2F40;
    localparam logic [13:0] SEG_H = 14'h1BC0;
    localparam logic [13:0] SEG_I = 14'h2412;
    localparam logic [13:0] SEG_J = 14'h1E00;
    localparam logic [13:0] SEG_K = 14'h0389;
    localparam logic [13:0] SEG_L = 14'h0700;
    localparam logic [13:0] SEG_M = 14'h1B28;
    localparam logic [13:0] SEG_N = 14'h1B21;
    localparam logic [13:0] SEG_O = 14'h3F00;
    localparam logic [13:0] SEG_P = 14'h33C0;
    localparam logic [13:0] SEG_Q = 14'h3F01;
    localparam logic [13:0] SEG_R = 14'h33C1;
    localparam logic [13:0] SEG_S = 14'h2C60;
    localparam logic [13:0] SEG_T = 14'h2012;
    localparam logic [13:0] SEG_U = 14'h1F00;
    localparam logic [13:0] SEG_V = 14'h030C;
    localparam logic [13:0] SEG_W = 14'h1B05;
    localparam logic [13:0] SEG_X = 14'h002D;
    localparam logic [13:0] SEG_Y = 14'h002A;
    localparam logic [13:0] SEG_Z = 14'h240C;
    localparam logic [13:0] SEG_SP = 14'h0000;

    typedef enum logic {HUNT, SYNC} scan_st_t;

    // Position of the set bit of a one-hot select (caller guarantees one-hot).
    function automatic logic [3:0] oh_index(input logic [NDIG-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

endpackage

// File: rtl/ita_scan_capture_decode.sv
// seg14_decode: combinational 14-segment pattern to character code lookup.
//   segm : observed segment pattern (bit 13 = segment a)
//   code : 0-35 glyph code, 36 space, 63 for any pattern not in the font
module seg14_decode
    import ita_scan_pkg::*;
(
    input  logic [13:0]   segm,
    output logic [CW-1:0] code
);

    always_comb begin
        code = CH_UNK;
        case (segm)
            SEG_0:  code = 6'd0;
            SEG_1:  code = 6'd1;
            SEG_2:  code = 6'd2;
            SEG_3:  code = 6'd3;
            SEG_4:  code = 6'd4;
            SEG_5:  code = 6'd5;
            SEG_6:  code = 6'd6;
            SEG_7:  code = 6'd7;
            SEG_8:  code = 6'd8;
            SEG_9:  code = 6'd9;
            SEG_A:  code = 6'd10;
            SEG_B:  code = 6'd11;
            SEG_C:  code = 6'd12;
            SEG_D:  code = 6'd13;
            SEG_E:  code = 6'd14;
            SEG_F:  code = 6'd15;
            SEG_G:  code = 6'd16;
            SEG_H:  code = 6'd17;
            SEG_I:  code = 6'd18;
            SEG_J:  code = 6'd19;
            SEG_K:  code = 6'd20;
            SEG_L:  code = 6'd21;
            SEG_M:  code = 6'd22;
            SEG_N:  code = 6'd23;
            SEG_O:  code = 6'd24;
            SEG_P:  code = 6'd25;
            SEG_Q:  code = 6'd26;
            SEG_R:  code = 6'd27;
            SEG_S:  code = 6'd28;
            SEG_T:  code = 6'd29;
            SEG_U:  code = 6'd30;
            SEG_V:  code = 6'd31;
            SEG_W:  code = 6'd32;
            SEG_X:  code = 6'd33;
            SEG_Y:  code = 6'd34;
            SEG_Z:  code = 6'd35;
            SEG_SP: code = CH_SPACE;
            default: code = CH_UNK;
        endcase
    end

endmodule

// File: rtl/ita_scan_capture.sv
// ita_scan_capture: receive-side monitor for the 12-digit multiplexed
// 14-segment display bus. Registers the bus, decodes each glyph and
// reassembles complete frames, flagging select and sequencing errors.
//   clk, rst     : clock, synchronous active-high reset
//   sel, segm    : observed one-hot digit select and segment pattern
//   frame        : last complete frame, digit i code in [6i+5:6i]
//   frame_valid  : one-cycle pulse when frame updates
//   frame_bad    : qualifies frame_valid, frame holds an unknown glyph
//   sel_err      : pulse, sel multi-hot
//   seq_err      : pulse, digit out of order or select held too long
//   frame_cnt    : good frames captured (saturating)
//   err_cnt      : sel_err + seq_err events (saturating)
module ita_scan_capture
    import ita_scan_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NDIG-1:0]      sel,
    input  logic [13:0]          segm,
    output logic [NDIG*CW-1:0]   frame,
    output logic                 frame_valid,
    output logic                 frame_bad,
    output logic                 sel_err,
    output logic                 seq_err,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           err_cnt
);

    logic [NDIG-1:0]          sel_q, prev_q;
    logic [13:0]              segm_q;
    logic [CW-1:0]            code;
    scan_st_t                 st;
    logic [3:0]               exp_q;
    logic [15:0]              rep_q, rep_nx;
    logic                     bad_q;
    logic [NDIG-1:0][CW-1:0]  wbuf;

    logic       is_zero, is_multi, is_rep, unk, timeout_hit;
    logic [3:0] idx;

    seg14_decode u_dec (
        .segm (segm_q),
        .code (code)
    );

    assign is_zero  = (sel_q == '0);
    assign is_multi = ((sel_q & (sel_q - 1'b1)) != '0);
    // prev_q only ever holds non-zero samples, so a blank between two
    // showings of the same digit still counts as a repeat.
    assign is_rep   = (sel_q == prev_q);
    assign idx      = oh_index(sel_q);
    assign unk      = (code == CH_UNK);
    assign rep_nx   = (rep_q == 16'hFFFF) ? rep_q : rep_q + 16'd1;
    assign timeout_hit = (TIMEOUT != 0) && (rep_nx == 16'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= '0;
            segm_q      <= '0;
            prev_q      <= '0;
            st          <= HUNT;
            exp_q       <= '0;
            rep_q       <= '0;
            bad_q       <= 1'b0;
            wbuf        <= {NDIG{CH_SPACE}};
            frame       <= {NDIG{CH_SPACE}};
            frame_valid <= 1'b0;
            frame_bad   <= 1'b0;
            sel_err     <= 1'b0;
            seq_err     <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            sel_q       <= sel;
            segm_q      <= segm;
            frame_valid <= 1'b0;
            sel_err     <= 1'b0;
            seq_err     <= 1'b0;

            if (is_zero) begin
                // blanking: nothing moves, timeout count is held
            end else if (is_multi) begin
                sel_err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                st     <= HUNT;
                prev_q <= sel_q;
                rep_q  <= '0;
            end else if (is_rep) begin
                rep_q <= rep_nx;
                if (st == SYNC) begin
                    wbuf[idx] <= code;
                    if (unk) bad_q <= 1'b1;
                    if (timeout_hit) begin
                        seq_err <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        st <= HUNT;
                    end
                end
            end else begin
                prev_q <= sel_q;
                rep_q  <= '0;
                if (st == HUNT) begin
                    if (idx == 4'd0) begin
                        wbuf[0] <= code;
                        bad_q   <= unk;
                        exp_q   <= 4'd1;
                        st      <= SYNC;
                    end
                end else if (idx == exp_q) begin
                    wbuf[idx] <= code;
                    if (unk) bad_q <= 1'b1;
                    exp_q <= exp_q + 4'd1;
                    if (idx == 4'(NDIG - 1)) begin
                        // commit straight from the buffer plus the last
                        // digit so frame is never seen half-written
                        frame       <= {code, wbuf[NDIG-2:0]};
                        frame_valid <= 1'b1;
                        frame_bad   <= bad_q | unk;
                        if (!(bad_q | unk) && frame_cnt != 16'hFFFF)
                            frame_cnt <= frame_cnt + 16'd1;
                        st <= HUNT;
                    end
                end else begin
                    seq_err <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    if (idx == 4'd0) begin
                        wbuf[0] <= code;
                        bad_q   <= unk;
                        exp_q   <= 4'd1;
                        st      <= SYNC;
                    end else begin
                        st <= HUNT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ita_scan_capture.sv
module tb_ita_scan_capture;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sel = '0;
    logic [13:0] segm = '0;
    logic [71:0] frame;
    logic        frame_valid, frame_bad, sel_err, seq_err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errs   = 0;

    ita_scan_capture #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .segm        (segm),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_bad   (frame_bad),
        .sel_err     (sel_err),
        .seq_err     (seq_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // font as the display drivers emit it
    function automatic logic [13:0] glyph(input int c);
        case (c)
            0: return 14'h3F0C;   1: return 14'h1808;   2: return 14'h36C0;
            3: return 14'h3C40;   4: return 14'h19C0;   5: return 14'h2DC0;
            6: return 14'h2FC0;   7: return 14'h3800;   8: return 14'h3FC0;
            9: return 14'h3DC0;  10: return 14'h3BC0;  11: return 14'h3C52;
           12: return 14'h2700;  13: return 14'h3C12;  14: return 14'h2780;
           15: return 14'h2380;  16: return 14'h2F40;  17: return 14'h1BC0;
           18: return 14'h2412;  19: return 14'h1E00;  20: return 14'h0389;
           21: return 14'h0700;  22: return 14'h1B28;  23: return 14'h1B21;
           24: return 14'h3F00;  25: return 14'h33C0;  26: return 14'h3F01;
           27: return 14'h33C1;  28: return 14'h2C60;  29: return 14'h2012;
           30: return 14'h1F00;  31: return 14'h030C;  32: return 14'h1B05;
           33: return 14'h002D;  34: return 14'h002A;  35: return 14'h240C;
           default: return 14'h0000;
        endcase
    endfunction

    function automatic int code_of(input byte ch);
        if (ch >= "0" && ch <= "9") return int'(ch) - 48;
        if (ch >= "A" && ch <= "Z") return int'(ch) - 55;
        return 36;
    endfunction

    function automatic int lookup(input logic [13:0] g);
        for (int c = 0; c <= 36; c++)
            if (glyph(c) == g) return c;
        return 63;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic        fv, fbad, se, qe;
        logic [71:0] frame;
        int          fcnt, ecnt;
    } exp_t;

    exp_t        q[$];
    bit          m_hunt;
    int          m_next, m_rep, m_fcnt, m_ecnt;
    bit          m_bad, m_fbad;
    logic [11:0] m_prev;
    int          m_dig[12];
    logic [71:0] m_frame;

    function automatic logic [71:0] spaces();
        logic [71:0] f;
        for (int i = 0; i < 12; i++) f[6*i +: 6] = 6'd36;
        return f;
    endfunction

    task automatic m_reset();
        m_hunt = 1; m_next = 0; m_rep = 0; m_fcnt = 0; m_ecnt = 0;
        m_bad = 0; m_fbad = 0; m_prev = '0; m_frame = spaces();
        for (int i = 0; i < 12; i++) m_dig[i] = 36;
    endtask

    task automatic m_err();
        if (m_ecnt < 255) m_ecnt++;
    endtask

    task automatic m_start(input int c);
        m_dig[0] = c; m_bad = (c == 63); m_next = 1; m_hunt = 0;
    endtask

    task automatic model(input logic [11:0] s, input logic [13:0] g, output exp_t e);
        int c, ix, ones;
        e.fv = 0; e.se = 0; e.qe = 0;
        c = lookup(g);
        ones = $countones(s);
        ix = 0;
        for (int i = 0; i < 12; i++) if (s[i]) ix = i;
        if (ones == 0) begin
        end else if (ones > 1) begin
            e.se = 1; m_err(); m_hunt = 1; m_prev = s; m_rep = 0;
        end else if (s == m_prev) begin
            m_rep++;
            if (!m_hunt) begin
                m_dig[ix] = c;
                if (c == 63) m_bad = 1;
                if (TO != 0 && m_rep == TO) begin
                    e.qe = 1; m_err(); m_hunt = 1;
                end
            end
        end else begin
            m_prev = s; m_rep = 0;
            if (m_hunt) begin
                if (ix == 0) m_start(c);
            end else if (ix == m_next) begin
                m_dig[ix] = c;
                if (c == 63) m_bad = 1;
                m_next++;
                if (ix == 11) begin
                    e.fv = 1;
                    for (int i = 0; i < 12; i++) m_frame[6*i +: 6] = 6'(m_dig[i]);
                    m_fbad = m_bad;
                    if (!m_bad && m_fcnt < 65535) m_fcnt++;
                    m_hunt = 1;
                end
            end else begin
                e.qe = 1; m_err();
                if (ix == 0) m_start(c); else m_hunt = 1;
            end
        end
        e.frame = m_frame; e.fbad = m_fbad; e.fcnt = m_fcnt; e.ecnt = m_ecnt;
    endtask

    // ---------------- stimulus helpers ----------------
    // Outputs for a sample appear two clocks after it is driven.
    task automatic step(input logic [11:0] s, input logic [13:0] g);
        exp_t e;
        @(negedge clk);
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("frame_valid", 72'(frame_valid), 72'(e.fv));
            chk("sel_err", 72'(sel_err), 72'(e.se));
            chk("seq_err", 72'(seq_err), 72'(e.qe));
            chk("frame", frame, e.frame);
            if (e.fv) chk("frame_bad", 72'(frame_bad), 72'(e.fbad));
            chk("frame_cnt", 72'(frame_cnt), 72'(e.fcnt));
            chk("err_cnt", 72'(err_cnt), 72'(e.ecnt));
        end
        sel = s; segm = g;
        model(s, g, e);
        q.push_back(e);
    endtask

    task automatic step_idx(input int i, input int c);
        logic [11:0] s;
        s = '0; s[i] = 1'b1;
        step(s, glyph(c));
    endtask

    task automatic drain();
        step('0, '0); step('0, '0);
    endtask

    task automatic send_str(input string str, input int hold, input bit blank);
        for (int i = 0; i < 12; i++) begin
            for (int h = 0; h < hold; h++) step_idx(i, code_of(str[i]));
            if (blank) step('0, '0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; sel = '0; segm = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        q.delete();
        m_reset();
        chk("rst_frame", frame, spaces());
        chk("rst_pulses", 72'({frame_valid, frame_bad, sel_err, seq_err}), 72'(0));
        chk("rst_fcnt", 72'(frame_cnt), 72'(0));
        chk("rst_ecnt", 72'(err_cnt), 72'(0));
    endtask

    task automatic rand_frame();
        int r, hold, c;
        logic [11:0] s;
        logic [13:0] g;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 99);
            c = $urandom_range(0, 36);
            s = '0; s[i] = 1'b1;
            g = glyph(c);
            if (r < 3) s = s | (12'b1 << $urandom_range(0, 11)) | 12'b1;
            else if (r < 6) begin s = '0; s[$urandom_range(0, 11)] = 1'b1; end
            else if (r < 9) g = 14'($urandom);
            hold = (r >= 9 && r < 11) ? 5 : $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) step(s, g);
            if ($urandom_range(0, 9) < 3) step('0, '0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [71:0] gold;
        int          codes[12] = '{15, 21, 24, 27, 36, 24, 27, 29, 36, 25, 10, 13};
        for (int i = 0; i < 12; i++) gold[6*i +: 6] = 6'(codes[i]);

        do_reset();

        // clean frame, one digit per clock
        send_str("FLOR ORT PAD", 1, 0);
        drain();
        chk("golden_frame", frame, gold);
        chk("golden_fcnt", 72'(frame_cnt), 72'(1));

        // three more frames back to back
        repeat (3) send_str("FLOR ORT PAD", 1, 0);
        drain();
        chk("b2b_fcnt", 72'(frame_cnt), 72'(4));
        chk("b2b_ecnt", 72'(err_cnt), 72'(0));

        // multi-hot select at the third digit, then a clean frame
        step_idx(0, 1); step_idx(1, 2);
        step(12'b000000000011, glyph(3));
        for (int i = 3; i < 12; i++) step_idx(i, i);
        send_str("0123456789AB", 1, 0);
        drain();
        chk("mh_ecnt", 72'(err_cnt), 72'(1));
        chk("mh_fcnt", 72'(frame_cnt), 72'(5));

        // out-of-order digit, then index 0 mid-frame resyncs
        step_idx(0, 1); step_idx(1, 2); step_idx(2, 3); step_idx(6, 4);
        step_idx(0, 5); step_idx(1, 6); step_idx(2, 7); step_idx(3, 8);
        for (int i = 0; i < 12; i++) step_idx(i, 35 - i);
        drain();
        chk("seq_ecnt", 72'(err_cnt), 72'(3));
        chk("seq_fcnt", 72'(frame_cnt), 72'(6));

        // unknown glyph at digit 5
        for (int i = 0; i < 12; i++)
            if (i == 4) step(12'h010, 14'h3FFF); else step_idx(i, i + 10);
        drain();
        chk("unk_code", 72'(frame[29:24]), 72'(63));
        chk("unk_fcnt", 72'(frame_cnt), 72'(6));

        // digit 2 held for six cycles trips the timeout
        step_idx(0, 0);
        repeat (6) step_idx(1, 1);
        for (int i = 2; i < 12; i++) step_idx(i, i);
        drain();
        chk("to_ecnt", 72'(err_cnt), 72'(4));

        // blanks between digits and three-cycle holds do not trip it
        send_str("HELLO WORLD ", 3, 1);
        drain();
        chk("blank_ecnt", 72'(err_cnt), 72'(4));
        chk("blank_fcnt", 72'(frame_cnt), 72'(7));

        // randomized frames with occasional protocol faults
        repeat (150) rand_frame();
        drain();

        // reset mid-frame
        for (int i = 0; i < 5; i++) step_idx(i, i);
        do_reset();
        step('0, '0);
        chk("post_rst_quiet", 72'({frame_valid, sel_err, seq_err}), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
